// File: rtl/uart_program_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
// Ports:
//   rx_data / rx_data_ready : received byte and its single-cycle valid pulse
//   mem_we / mem_addr / mem_wdata : one-cycle full-word write to instruction memory
// The master modport is the loader side; the slave modport is the UART/memory side.
interface uart_program_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_data_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  rx_data,
        input  rx_data_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_data,
        output rx_data_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/uart_program_loader.sv
// Parses a framed UART byte stream (sync, LE 16-bit word count, LE 32-bit words,
// XOR checksum) and issues one word write per assembled instruction.
// Ports:
//   clk_100MHz, rst_n : clock, async active-low reset
//   enable            : loader mode; low forces IDLE
//   bus               : rx byte input and memory write output (master side)
//   busy/done/error   : frame in progress / last frame good (sticky) / last frame aborted (sticky)
//   error_code        : 0 none, 1 checksum, 2 timeout, 3 overflow
//   words_loaded      : words written in the current or last frame
module uart_program_loader #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic                  clk_100MHz,
    input  logic                  rst_n,
    input  logic                  enable,
    uart_program_loader_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code,
    output logic [ADDR_W:0]       words_loaded
);

    localparam int unsigned TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0] MAX_CNT  = 17'(2 ** ADDR_W);

    localparam logic [1:0] EC_NONE = 2'd0;
    localparam logic [1:0] EC_CSUM = 2'd1;
    localparam logic [1:0] EC_TMO  = 2'd2;
    localparam logic [1:0] EC_OVF  = 2'd3;

    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       wbuf_q, wbuf_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        ecode_q, ecode_d;
    logic [ADDR_W:0]   words_q, words_d;

    logic              in_frame_c;
    logic [15:0]       cnt_new_c;

    // State and datapath registers
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            csum_q      <= '0;
            lane_q      <= '0;
            wbuf_q      <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ecode_q     <= EC_NONE;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            lane_q      <= lane_d;
            wbuf_q      <= wbuf_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            ecode_q     <= ecode_d;
            words_q     <= words_d;
        end
    end

    // Frame parser: next state and register updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        lane_d      = lane_q;
        wbuf_d      = wbuf_q;
        tmo_d       = tmo_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        error_d     = error_q;
        ecode_d     = ecode_q;
        words_d     = words_q;
        cnt_new_c   = {bus.rx_data, cnt_q[7:0]};
        in_frame_c  = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                      (state_q == DATA)   || (state_q == CSUM);

        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE, ERR: begin
                    if (bus.rx_data_ready && (bus.rx_data == SYNC_BYTE)) begin
                        state_d = CNT_LO;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                        ecode_d = EC_NONE;
                        words_d = '0;
                        csum_d  = '0;
                        lane_d  = '0;
                        tmo_d   = '0;
                    end
                end
                CNT_LO: begin
                    if (bus.rx_data_ready) begin
                        cnt_d[7:0] = bus.rx_data;
                        csum_d     = csum_q ^ bus.rx_data;
                        state_d    = CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (bus.rx_data_ready) begin
                        cnt_d  = cnt_new_c;
                        csum_d = csum_q ^ bus.rx_data;
                        if (17'(cnt_new_c) > MAX_CNT) begin
                            state_d = ERR;
                            error_d = 1'b1;
                            ecode_d = EC_OVF;
                        end else if (cnt_new_c == 16'd0) begin
                            state_d = CSUM;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (bus.rx_data_ready) begin
                        csum_d = csum_q ^ bus.rx_data;
                        lane_d = lane_q + 2'd1;
                        unique case (lane_q)
                            2'd0: wbuf_d[7:0]   = bus.rx_data;
                            2'd1: wbuf_d[15:8]  = bus.rx_data;
                            2'd2: wbuf_d[23:16] = bus.rx_data;
                            default: begin
                                // Lane 3 completes the word: write it next cycle at the current index
                                mem_we_d    = 1'b1;
                                mem_addr_d  = words_q[ADDR_W-1:0];
                                mem_wdata_d = {bus.rx_data, wbuf_q};
                                words_d     = words_q + (ADDR_W+1)'(1);
                                if ((16'(words_q) + 16'd1) == cnt_q) begin
                                    state_d = CSUM;
                                end
                            end
                        endcase
                    end
                end
                CSUM: begin
                    if (bus.rx_data_ready) begin
                        if (bus.rx_data == csum_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ERR;
                            error_d = 1'b1;
                            ecode_d = EC_CSUM;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // Inter-byte timeout; a byte on the expiry cycle takes priority
            if (in_frame_c) begin
                if (bus.rx_data_ready) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                    error_d = 1'b1;
                    ecode_d = EC_TMO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
        end

        busy_d = (state_d == CNT_LO) || (state_d == CNT_HI) ||
                 (state_d == DATA)   || (state_d == CSUM);
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign error_code    = ecode_q;
    assign words_loaded  = words_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: frame table plus hand-written
// timeout, overflow-boundary, abort and async-reset sequences.
module tb_uart_program_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned TMO    = 40;

    logic              clk_100MHz = 1'b0;
    logic              rst_n      = 1'b0;
    logic              enable     = 1'b0;
    logic              busy, done, error;
    logic [1:0]        error_code;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_program_loader #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TMO),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .rst_n        (rst_n),
        .enable       (enable),
        .bus          (bus.master),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .error_code   (error_code),
        .words_loaded (words_loaded)
    );

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    typedef struct {
        logic [127:0] bytes;   // first byte sent is the most significant of the n used
        int           n;
        logic         done;
        logic         err;
        logic [1:0]   code;
        logic [10:0]  words;
        int           nwr;
        logic [31:0]  w0;
        logic [31:0]  w1;
    } vec_t;

    wr_t  wq[$];
    vec_t vecs[6];
    int   n_vec = 0;
    int   n_bad = 0;

    // Record every memory write strobe, sampled away from the active edge
    always @(negedge clk_100MHz) begin
        if (bus.mem_we === 1'b1) begin
            wq.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_100MHz);
        bus.rx_data       = b;
        bus.rx_data_ready = 1'b1;
        @(negedge clk_100MHz);
        bus.rx_data_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        idle(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.rx_data       = 8'h00;
        bus.rx_data_ready = 1'b0;

        vecs[0] = '{128'h3CA5000000, 5, 1'b1, 1'b0, 2'd0, 11'd0, 0, 32'h0, 32'h0};
        vecs[1] = '{128'hA50200130000009300100092, 12, 1'b1, 1'b0, 2'd0, 11'd2, 2,
                    32'h00000013, 32'h00100093};
        vecs[2] = '{128'hA50200130000009300100091, 12, 1'b0, 1'b1, 2'd1, 11'd2, 2,
                    32'h00000013, 32'h00100093};
        vecs[3] = '{128'hA50104, 3, 1'b0, 1'b1, 2'd3, 11'd0, 0, 32'h0, 32'h0};
        vecs[4] = '{128'hA50100A5A5A5A501, 8, 1'b1, 1'b0, 2'd0, 11'd1, 1,
                    32'hA5A5A5A5, 32'h0};
        vecs[5] = '{128'hA50100EFBEADDE23, 8, 1'b1, 1'b0, 2'd0, 11'd1, 1,
                    32'hDEADBEEF, 32'h0};

        // Reset state
        idle(2);
        chk("rst busy",   64'(busy), 64'd0);
        chk("rst done",   64'(done), 64'd0);
        chk("rst error",  64'(error), 64'd0);
        chk("rst code",   64'(error_code), 64'd0);
        chk("rst words",  64'(words_loaded), 64'd0);
        chk("rst mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst addr",   64'(bus.mem_addr), 64'd0);
        chk("rst wdata",  64'(bus.mem_wdata), 64'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        idle(2);

        // Frame table
        for (int i = 0; i < 6; i++) begin
            wq.delete();
            for (int k = 0; k < vecs[i].n; k++) begin
                send_gap(vecs[i].bytes[8*(vecs[i].n-1-k) +: 8]);
            end
            chk($sformatf("v%0d done", i),   64'(done), 64'(vecs[i].done));
            chk($sformatf("v%0d error", i),  64'(error), 64'(vecs[i].err));
            chk($sformatf("v%0d code", i),   64'(error_code), 64'(vecs[i].code));
            chk($sformatf("v%0d words", i),  64'(words_loaded), 64'(vecs[i].words));
            chk($sformatf("v%0d busy", i),   64'(busy), 64'd0);
            chk($sformatf("v%0d nwrites", i), 64'(wq.size()), 64'(vecs[i].nwr));
            if (wq.size() > 0) begin
                chk($sformatf("v%0d addr0", i), 64'(wq[0].a), 64'd0);
                chk($sformatf("v%0d data0", i), 64'(wq[0].d), 64'(vecs[i].w0));
            end
            if (wq.size() > 1) begin
                chk($sformatf("v%0d addr1", i), 64'(wq[1].a), 64'd1);
                chk($sformatf("v%0d data1", i), 64'(wq[1].d), 64'(vecs[i].w1));
            end
        end

        // Timeout fires exactly TMO cycles after the last byte
        wq.delete();
        send_gap(8'hA5);
        send_gap(8'h02);
        send_gap(8'h00);
        send_byte(8'h13);
        idle(TMO - 1);
        chk("tmo pre error", 64'(error), 64'd0);
        chk("tmo pre busy",  64'(busy), 64'd1);
        idle(1);
        chk("tmo error", 64'(error), 64'd1);
        chk("tmo code",  64'(error_code), 64'd2);
        chk("tmo busy",  64'(busy), 64'd0);
        chk("tmo nwrites", 64'(wq.size()), 64'd0);

        // A byte on the expiry cycle keeps the frame alive
        wq.delete();
        send_gap(8'hA5);
        send_gap(8'h02);
        send_gap(8'h00);
        send_byte(8'h13);
        idle(TMO - 2);
        send_byte(8'h00);
        chk("expiry byte error", 64'(error), 64'd0);
        chk("expiry byte busy",  64'(busy), 64'd1);
        send_gap(8'h00);
        send_gap(8'h00);
        send_gap(8'h93);
        send_gap(8'h00);
        send_gap(8'h10);
        send_gap(8'h00);
        send_gap(8'h92);
        chk("expiry done",  64'(done), 64'd1);
        chk("expiry words", 64'(words_loaded), 64'd2);
        chk("expiry nwrites", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            chk("expiry data1", 64'(wq[1].d), 64'h00100093);
        end

        // Count 1024 accepted; write latency; enable drop mid-DATA
        wq.delete();
        send_gap(8'hA5);
        send_gap(8'h00);
        send_gap(8'h04);
        chk("cnt1024 busy",  64'(busy), 64'd1);
        chk("cnt1024 error", 64'(error), 64'd0);
        send_gap(8'h11);
        send_gap(8'h22);
        send_gap(8'h33);
        send_byte(8'h44);
        chk("lat mem_we", 64'(bus.mem_we), 64'd1);
        chk("lat addr",   64'(bus.mem_addr), 64'd0);
        chk("lat wdata",  64'(bus.mem_wdata), 64'h44332211);
        chk("lat words",  64'(words_loaded), 64'd1);
        idle(1);
        chk("we one cycle", 64'(bus.mem_we), 64'd0);
        chk("hold wdata",   64'(bus.mem_wdata), 64'h44332211);
        idle(2);
        send_gap(8'h55);
        send_byte(8'h66);
        enable = 1'b0;
        idle(1);
        chk("abort busy", 64'(busy), 64'd0);
        send_gap(8'h77);
        send_gap(8'h88);
        chk("abort nwrites", 64'(wq.size()), 64'd1);
        chk("abort words",   64'(words_loaded), 64'd1);
        chk("abort error",   64'(error), 64'd0);
        enable = 1'b1;
        send_gap(8'h3C);
        chk("idle garbage busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-frame
        send_gap(8'hA5);
        send_gap(8'h02);
        send_gap(8'h00);
        send_gap(8'h13);
        send_gap(8'h00);
        send_gap(8'h00);
        send_gap(8'h00);
        send_gap(8'h93);
        chk("pre-rst words", 64'(words_loaded), 64'd1);
        chk("pre-rst busy",  64'(busy), 64'd1);
        @(negedge clk_100MHz);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy",  64'(busy), 64'd0);
        chk("arst done",  64'(done), 64'd0);
        chk("arst error", 64'(error), 64'd0);
        chk("arst code",  64'(error_code), 64'd0);
        chk("arst words", 64'(words_loaded), 64'd0);
        chk("arst we",    64'(bus.mem_we), 64'd0);
        chk("arst addr",  64'(bus.mem_addr), 64'd0);
        chk("arst wdata", 64'(bus.mem_wdata), 64'd0);
        @(negedge clk_100MHz);
        rst_n = 1'b1;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
